// File: rtl/ariane_pkg.sv
// Shared core types: branch-resolve record and the performance event codes.
package ariane_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned PERF_SEL_W = 4;

   typedef struct packed {
      logic valid;
      logic is_mispredict;
   } bp_resolve_t;

   typedef enum logic [PERF_SEL_W-1:0] {
      EvNone       = 4'd0,
      EvIcacheMiss = 4'd1,
      EvDcacheMiss = 4'd2,
      EvItlbMiss   = 4'd3,
      EvDtlbMiss   = 4'd4,
      EvInstrRet   = 4'd5,
      EvException  = 4'd6,
      EvEret       = 4'd7,
      EvBranch     = 4'd8,
      EvMispredict = 4'd9,
      EvSbFull     = 4'd10,
      EvIfEmpty    = 4'd11
   } perf_event_e;

   // Reserved codes 12..15 collapse to "no event" so software can probe for support.
   function automatic logic [PERF_SEL_W-1:0] legalize_sel(input logic [PERF_SEL_W-1:0] code);
      return (code > 4'd11) ? '0 : code;
   endfunction

endpackage

// File: rtl/perf_commit_count.sv
// Counts commit ports that are both valid and acknowledged this cycle.
module perf_commit_count #(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1)
) (
   input  logic [NR_COMMIT_PORTS-1:0] commit_instr_i,
   input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
   output logic [CW-1:0]              count_o
);

   // Masked popcount over all commit ports.
   always_comb begin
      count_o = '0;
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
         count_o = count_o + CW'(commit_instr_i[p] & commit_ack_i[p]);
      end
   end

endmodule

// File: rtl/perf_event_sel.sv
// Per-counter event selection with inhibit and debug gating; one-cycle registered increments.
module perf_event_sel
   import ariane_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NUM_CNT         = 6,
   localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             debug_mode_i,
   input  logic [4:0]                       addr_i,
   input  logic                             we_i,
   input  logic [XLEN-1:0]                  data_i,
   output logic [XLEN-1:0]                  data_o,
   input  logic [NR_COMMIT_PORTS-1:0]       commit_instr_i,
   input  logic [NR_COMMIT_PORTS-1:0]       commit_ack_i,
   input  logic                             l1_icache_miss_i,
   input  logic                             l1_dcache_miss_i,
   input  logic                             itlb_miss_i,
   input  logic                             dtlb_miss_i,
   input  logic                             sb_full_i,
   input  logic                             if_empty_i,
   input  logic                             ex_i,
   input  logic                             eret_i,
   input  bp_resolve_t                      resolved_branch_i,
   output logic [NUM_CNT-1:0][CW-1:0]       inc_o
);

   logic [NUM_CNT-1:0][PERF_SEL_W-1:0] r_sel;
   logic [NUM_CNT-1:0]                 r_inhibit;
   logic [NUM_CNT-1:0][CW-1:0]         r_inc;
   logic [NUM_CNT-1:0][CW-1:0]         w_inc_d;
   logic [CW-1:0]                      w_commit_cnt;
   logic [CW-1:0]                      w_ev [16];
   logic                               w_unused_data;

   // Upper data bits are architecturally ignored on writes.
   assign w_unused_data = ^data_i;

   perf_commit_count #(
      .NR_COMMIT_PORTS (NR_COMMIT_PORTS)
   ) u_commit_count (
      .commit_instr_i (commit_instr_i),
      .commit_ack_i   (commit_ack_i),
      .count_o        (w_commit_cnt)
   );

   // CSR writes to select and inhibit registers; reserved select codes stored as 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sel     <= '0;
         r_inhibit <= '0;
      end else if (we_i) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (addr_i == 5'(i)) begin
               r_sel[i] <= legalize_sel(data_i[PERF_SEL_W-1:0]);
            end
         end
         if (addr_i == 5'd31) begin
            r_inhibit <= data_i[NUM_CNT-1:0];
         end
      end
   end

   // Combinational CSR read, zero-extended; unmapped addresses read 0.
   always_comb begin
      data_o = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (addr_i == 5'(i)) begin
            data_o[PERF_SEL_W-1:0] = r_sel[i];
         end
      end
      if (addr_i == 5'd31) begin
         data_o[NUM_CNT-1:0] = r_inhibit;
      end
   end

   // Event vector indexed by event code; unused codes stay 0.
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         w_ev[k] = '0;
      end
      w_ev[EvIcacheMiss] = CW'(l1_icache_miss_i);
      w_ev[EvDcacheMiss] = CW'(l1_dcache_miss_i);
      w_ev[EvItlbMiss]   = CW'(itlb_miss_i);
      w_ev[EvDtlbMiss]   = CW'(dtlb_miss_i);
      w_ev[EvInstrRet]   = w_commit_cnt;
      w_ev[EvException]  = CW'(ex_i);
      w_ev[EvEret]       = CW'(eret_i);
      w_ev[EvBranch]     = CW'(resolved_branch_i.valid);
      w_ev[EvMispredict] = CW'(resolved_branch_i.valid & resolved_branch_i.is_mispredict);
      w_ev[EvSbFull]     = CW'(sb_full_i);
      w_ev[EvIfEmpty]    = CW'(if_empty_i);
   end

   // Select per counter using the current (pre-write) select, gated by debug and inhibit.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         w_inc_d[i] = '0;
         if (!debug_mode_i && !r_inhibit[i]) begin
            w_inc_d[i] = w_ev[r_sel[i]];
         end
      end
   end

   // Single pipeline stage: each increment is presented for exactly one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_inc <= '0;
      end else begin
         r_inc <= w_inc_d;
      end
   end

   assign inc_o = r_inc;

endmodule
